// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and the receivers on the same line.
package serial_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Frame length in bit periods; multiply by BIT_CYCLES for clock cycles.
    function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/serial_tx_fsm_if.sv
// Byte handshake plus serial line and status for the serial transmitter.
interface serial_tx_fsm_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              out;
    logic              busy;
    logic              done;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: strobes bit_end_o on the last cycle of every BIT_CYCLES-cycle period.
module serial_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic bit_end_o
);
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // With BIT_CYCLES=1 LAST is 0 and the counter never leaves 0, so bit_end follows en.
    assign bit_end_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_tx_fsm.sv
// Serial byte transmitter: start bit, data, optional odd parity, stop bit(s); line idles high.
module serial_tx_fsm
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_tx_fsm_if.slave tx
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              out_q, out_d;

    logic              bit_end;
    logic              last_stop_end;
    logic              ready;
    logic              accept;
    logic              next_bit;
    logic [DATA_W-1:0] shifted;

    serial_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (state_q != IDLE),
        .bit_end_o (bit_end)
    );

    assign last_stop_end = (state_q == STOP) && bit_end && (bit_q == LAST_STOP);
    assign ready         = (state_q == IDLE) || last_stop_end;
    assign accept        = tx.in_valid && ready;

    // The register always presents the next bit to send at its head.
    assign next_bit = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
    assign shifted  = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, shift_q[DATA_W-1:1]};

    assign tx.in_ready = ready;
    assign tx.out      = out_q;
    assign tx.busy     = (state_q != IDLE);
    assign tx.done     = last_stop_end;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        out_d    = out_q;

        case (state_q)
            IDLE: ;
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    out_d   = next_bit;
                    shift_d = shifted;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q != LAST_DATA) begin
                        bit_d   = bit_q + CNT_W'(1);
                        out_d   = next_bit;
                        shift_d = shifted;
                    end else if (PARITY_EN != 0) begin
                        state_d = PARITY;
                        out_d   = parity_q;
                    end else begin
                        state_d = STOP;
                        bit_d   = '0;
                        out_d   = STOP_BIT;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                    out_d   = STOP_BIT;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = IDLE;
                        out_d   = IDLE_LEVEL;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = IDLE_LEVEL;
            end
        endcase

        // Accept only happens in IDLE or the final stop cycle, so it overrides either path.
        if (accept) begin
            state_d  = START;
            bit_d    = '0;
            shift_d  = tx.in_byte;
            parity_d = ~^tx.in_byte;
            out_d    = START_BIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            out_q    <= IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            out_q    <= out_d;
        end
    end
endmodule

// File: tb/tb_serial_tx_fsm.sv
// Directed bench for serial_tx_fsm: four parameterisations selected one at a time.
module tb_serial_tx_fsm;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       tbValid = 1'b0;
    logic [7:0] tbByte  = 8'h00;
    int         sel     = 0;
    logic [3:0] obs;
    int         compareCount = 0;
    int         failCount    = 0;
    vec_t       vecs [12];

    always #5 clk = ~clk;

    serial_tx_fsm_if #(.DATA_W(8)) if0 ();
    serial_tx_fsm_if #(.DATA_W(8)) if1 ();
    serial_tx_fsm_if #(.DATA_W(8)) if2 ();
    serial_tx_fsm_if #(.DATA_W(8)) if3 ();

    assign if0.in_byte  = tbByte;
    assign if1.in_byte  = tbByte;
    assign if2.in_byte  = tbByte;
    assign if3.in_byte  = tbByte;
    assign if0.in_valid = tbValid && (sel == 0);
    assign if1.in_valid = tbValid && (sel == 1);
    assign if2.in_valid = tbValid && (sel == 2);
    assign if3.in_valid = tbValid && (sel == 3);

    serial_tx_fsm #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0), .STOP_BITS(1), .BIT_CYCLES(1))
        dut0 (.clk(clk), .reset_n(reset_n), .tx(if0));
    serial_tx_fsm #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(1), .STOP_BITS(1), .BIT_CYCLES(1))
        dut1 (.clk(clk), .reset_n(reset_n), .tx(if1));
    serial_tx_fsm #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0), .STOP_BITS(2), .BIT_CYCLES(1))
        dut2 (.clk(clk), .reset_n(reset_n), .tx(if2));
    serial_tx_fsm #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(0), .STOP_BITS(1), .BIT_CYCLES(4))
        dut3 (.clk(clk), .reset_n(reset_n), .tx(if3));

    // Observed {out, busy, done, in_ready} of the selected instance.
    always_comb begin
        case (sel)
            1:       obs = {if1.out, if1.busy, if1.done, if1.in_ready};
            2:       obs = {if2.out, if2.busy, if2.done, if2.in_ready};
            3:       obs = {if3.out, if3.busy, if3.done, if3.in_ready};
            default: obs = {if0.out, if0.busy, if0.done, if0.in_ready};
        endcase
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        tbValid = v;
        tbByte  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: out/busy/done/ready got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [7:0] got, input logic [7:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // bits holds the line levels bit period by bit period, first on the line at bit 0.
    task automatic checkFrame(input string name, input logic [15:0] bits, input int nbits,
                              input int bc, input logic nv, input logic [7:0] nb);
        logic [15:0] tmp;
        logic        last;
        for (int c = 0; c < nbits * bc; c++) begin
            tmp  = bits >> (c / bc);
            last = (c == nbits * bc - 1);
            checkOutput($sformatf("%s[%0d]", name, c), {tmp[0], 1'b1, last, last});
            if (!last) applyStimulus(nv, nb);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t reached limit", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bytes6 [3];
        logic [9:0] line;
        int         doneCnt;
        int         donePos;

        // 8'hA5 LSB first on the defaults: start, 1,0,1,0,0,1,0,1, stop, then idle.
        vecs[0]  = '{1'b1, 8'hA5, 4'b0100};
        vecs[1]  = '{1'b0, 8'h00, 4'b1100};
        vecs[2]  = '{1'b0, 8'h00, 4'b0100};
        vecs[3]  = '{1'b0, 8'h00, 4'b1100};
        vecs[4]  = '{1'b0, 8'h00, 4'b0100};
        vecs[5]  = '{1'b0, 8'h00, 4'b0100};
        vecs[6]  = '{1'b0, 8'h00, 4'b1100};
        vecs[7]  = '{1'b0, 8'h00, 4'b0100};
        vecs[8]  = '{1'b0, 8'h00, 4'b1100};
        vecs[9]  = '{1'b0, 8'h00, 4'b1111};
        vecs[10] = '{1'b0, 8'h00, 4'b1001};
        vecs[11] = '{1'b0, 8'h00, 4'b1001};

        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            checkOutput($sformatf("reset_dut%0d", k), 4'b1001);
        end
        reset_n = 1'b1;
        sel = 0;
        applyStimulus(1'b0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("t1_vec%0d", i), vecs[i].exp);
        end

        // Odd parity: 8'hA5 has four ones -> 1, 8'h01 has one -> 0.
        sel = 1;
        #1;
        applyStimulus(1'b1, 8'hA5);
        checkFrame("t2_a5", 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 1, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2_gap", 4'b1001);
        applyStimulus(1'b1, 8'h01);
        checkFrame("t2_01", 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 1, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2_idle", 4'b1001);

        // Valid held high: 8'hFF waits until the final stop cycle of the 8'h3C frame.
        sel = 2;
        #1;
        applyStimulus(1'b1, 8'h3C);
        checkFrame("t3_3c", 16'({2'b11, 8'h3C, 1'b0}), 11, 1, 1'b1, 8'hFF);
        applyStimulus(1'b1, 8'hFF);
        checkFrame("t3_ff", 16'({2'b11, 8'hFF, 1'b0}), 11, 1, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t3_idle", 4'b1001);

        // 8'h80 MSB first puts a single 1 right after the start bit; 4 cycles per bit.
        sel = 3;
        #1;
        applyStimulus(1'b1, 8'h80);
        checkFrame("t4_80", 16'({1'b1, 8'h01, 1'b0}), 10, 4, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t4_idle", 4'b1001);

        // Reset during data bit 3 of 8'hA5 (that bit is 0), then a clean 8'h5A frame.
        sel = 0;
        #1;
        applyStimulus(1'b1, 8'hA5);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00);
        checkOutput("t5_bit3", 4'b0100);
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00);
        reset_n = 1'b1;
        checkOutput("t5_reset", 4'b1001);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t5_nodone", 4'b1001);
        applyStimulus(1'b1, 8'h5A);
        checkFrame("t5_5a", 16'({1'b1, 8'h5A, 1'b0}), 10, 1, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t5_idle", 4'b1001);

        // Loopback: decode the line as an LSB-first 8N1 receiver would, frames back to back.
        bytes6[0] = 8'h00;
        bytes6[1] = 8'hFF;
        bytes6[2] = 8'hA5;
        applyStimulus(1'b1, bytes6[0]);
        for (int f = 0; f < 3; f++) begin
            line    = '0;
            doneCnt = 0;
            donePos = -1;
            for (int c = 0; c < 10; c++) begin
                line = {obs[3], line[9:1]};
                if (obs[1]) begin
                    doneCnt++;
                    donePos = c;
                end
                if (c < 9)       applyStimulus(1'b0, 8'h00);
                else if (f < 2)  applyStimulus(1'b1, bytes6[f+1]);
                else             applyStimulus(1'b0, 8'h00);
            end
            checkValue($sformatf("t6_byte%0d", f), line[8:1], bytes6[f]);
            checkValue($sformatf("t6_framing%0d", f), {6'b0, line[9], line[0]}, 8'h02);
            checkValue($sformatf("t6_done%0d", f), 8'(doneCnt * 16 + donePos), 8'h19);
        end
        checkOutput("t6_idle", 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule

// File: doc/serial_tx_fsm.md
Name: serial_tx_fsm

Overview:
Serial byte transmitter, the transmit end of the one-bit-per-tick serial line that serial_fsm and serial_fsm2 receive. Accepts parallel bytes over a valid/ready handshake and sends each as a frame on a single line: start bit 0, data bits, optional odd parity, then stop bit(s) 1. The line idles high. Sits in front of a serial_fsm-class receiver in loopback and system benches.

Parameters:
DATA_W, 8, data bits per frame (5..9)
MSB_FIRST, 0, 0 = data LSB first; 1 = data MSB first
PARITY_EN, 0, 1 = insert odd parity bit after data
STOP_BITS, 1, number of stop bits (1 or 2)
BIT_CYCLES, 1, clock cycles per bit (>=1); 1 matches serial_fsm timing

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_byte  input  DATA_W  byte to send; sampled on accept
in_valid  input  1  in_byte is valid
in_ready  output  1  transmitter can accept a byte this cycle
out  output  1  serial line; idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE, out=1, busy=0, done=0, bit and cycle counters 0, shift register 0. Reset mid-frame aborts the frame. out is 1 from the next edge, and no done pulse is issued.
- Accept: transfer occurs on an edge where in_valid && in_ready. in_byte is latched, and parity (odd parity, i.e. ~^in_byte) is latched at the same edge.
- in_ready = (state==IDLE) || (final cycle of the last stop bit). Combinational from state and counters. It must not depend on in_valid.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE, or START again if an accept occurs in the final stop cycle.
- Each non-IDLE bit holds out for exactly BIT_CYCLES cycles, using a cycle counter 0..BIT_CYCLES-1. The bit advances when the counter reaches BIT_CYCLES-1.
- Latency: accept at edge N gives out=0 (start) from edge N through edge N+BIT_CYCLES.
- DATA: DATA_W bits, order set by MSB_FIRST, using a bit counter 0..DATA_W-1.
- STOP: out=1 for STOP_BITS*BIT_CYCLES cycles.
- Frame length = (1+DATA_W+PARITY_EN+STOP_BITS)*BIT_CYCLES cycles. With defaults this is 10 cycles.
- done=1 for exactly one cycle, the final cycle of the last stop bit. It coincides with in_ready=1 in that cycle.
- Back-to-back: an accept in the final stop cycle starts the next START with no idle gap.
- busy = (state != IDLE).
- out is registered and glitch-free. It changes only at bit boundaries.
- in_byte changes after accept have no effect on the current frame.
- in_valid without in_ready: the byte is not taken. The upstream must hold it until ready.

Decomposition:
- Package serial_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1;
  - a function frame_len(DATA_W, PARITY_EN, STOP_BITS).
  The receivers share this package.
- Sub-module serial_bit_timer: cycle counter producing a bit_end strobe every BIT_CYCLES cycles while enabled. It clears when disabled or in reset. With BIT_CYCLES=1, bit_end is constant 1 while enabled.

Test Plan:
1. Defaults, send 8'hA5 once -> out sequence from accept edge: 0, 1,0,1,0,0,1,0,1, 1. done pulses in cycle 10, then out stays 1, busy=0, in_ready=1.
2. PARITY_EN=1, bytes 8'hA5 then 8'h01 -> parity bit 1 for A5 (four ones) and 0 for 01 (one one). Frames are 11 cycles.
3. in_valid held high with bytes 8'h3C then 8'hFF, STOP_BITS=2 -> second start bit immediately follows the second stop bit. Frames are contiguous at 11 cycles each, with one done per frame.
4. BIT_CYCLES=4, MSB_FIRST=1, send 8'h80 -> start 0 for 4 cycles, then 1 for 4 cycles, then 0 for 28 cycles, then stop 1 for 4 cycles. The frame is 40 cycles.
5. reset_n=0 for one edge during data bit 3 -> out=1 next cycle, busy=0, no done. A following 8'h5A frame is correct.
6. Loopback into serial_fsm (defaults, MSB_FIRST matching its bit order) with bytes 8'h00, 8'hFF, 8'hA5 -> receiver out_byte matches each byte, receiver done aligns with each frame, and no framing errors occur.
